mod_updown_counter: RTL and testbench
=====================================

# mod_updown_counter

Parametrised, programmable-modulus up/down counter. Generalises the fixed 3-bit wrap-at-7 up counter:
- configurable width
- runtime terminal value
- direction select, synchronous load and clear
- clock-enable prescaler
- registered terminal-count pulse and sticky overflow flag

It is used wherever the design needs event or timebase counting with a non-power-of-two period.

## Interface
- WIDTH, 8, counter width in bits (≥2)
- PRESC_W, 4, prescaler control width (≥1)

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-low reset
- en  in  1  count enable; gates the prescaler
- up  in  1  direction: 1 = up, 0 = down; sampled on each tick
- clr  in  1  synchronous clear
- load  in  1  synchronous load
- load_val  in  WIDTH  value for load
- limit  in  WIDTH  terminal value; count range is 0..limit (period limit+1)
- presc  in  PRESC_W  tick every presc+1 enabled cycles
- count  out  WIDTH  current count, registered
- tc  out  1  terminal-count pulse, registered, one cycle per wrap
- ovf  out  1  sticky: set on any wrap

## Operation
- Internal prescaler presc_cnt (PRESC_W bits).
  - tick = en && (presc_cnt == presc).
  - On tick, presc_cnt <= 0.
  - Else if en, presc_cnt <= presc_cnt + 1.
  - Else presc_cnt holds.
- Per-edge priority: clr > load > tick > hold.
- clr:
  - count <= 0, presc_cnt <= 0, tc <= 0, ovf <= 0.
- load:
  - count <= min(load_val, limit), presc_cnt <= 0, tc <= 0.
  - ovf unchanged.
- Tick, up=1:
  - If count ≥ limit: count <= 0, tc <= 1 (wrap).
  - Else: count <= count + 1.
- Tick, up=0:
  - If count == 0: count <= limit, tc <= 1 (wrap).
  - If count > limit: count <= limit, tc <= 0. This handles limit lowered at runtime.
  - Else: count <= count − 1.
- tc is 0 on every edge without a wrap.
- ovf <= 1 on every wrap. It is cleared only by clr or rst.
- limit == 0: count stays 0; every tick is a wrap (tc high on every tick).
- limit == 2^WIDTH−1: full-range wrap; no arithmetic overflow beyond WIDTH bits.
- Arithmetic is unsigned, WIDTH bits.
- Comparisons use the current limit, sampled on the same edge.
- Direction change takes effect on the next tick. There is no extra latency and no prescaler restart.
- presc changed mid-count:
  - If presc_cnt > new presc, the prescaler counts up to 2^PRESC_W−1, rolls over to 0, then resumes normally.
  - No tick is generated at rollover unless presc_cnt == presc.

## Timing
- Reset (rst low, asynchronous): count = 0, tc = 0, ovf = 0, presc_cnt = 0, all immediately.
- Deassertion is synchronised externally. The first tick can occur on the first edge with rst high.
- Latency:
  - count, tc and ovf update on the rising edge where the condition is sampled.
  - tc is high in the same cycle count shows the wrapped value.
- With presc = P and en held high, count advances once every P+1 cycles.
  - The first tick after reset/clr/load comes P+1 edges after that event.
- Reset mid-operation: all state is abandoned; no tc is emitted for the interrupted period.
- Simultaneous events:
  - clr with load: clr wins.
  - load with tick: load wins; no wrap and no tc.
  - en low with load: load still applies.

## Test plan
- Reset, WIDTH=8, limit=5, presc=0, up=1, en=1 for 14 cycles -> count 0,1,2,3,4,5,0,1,...; tc high exactly on the two cycles count returns to 0; ovf=1 after the first wrap.
- up=0, limit=5, start 0 -> count 5,4,3,2,1,0,5; tc high when count becomes 5 from 0.
- presc=3, en=1 -> count increments every 4th cycle. Drop en for 5 cycles mid-period -> count and prescaler freeze; count resumes with the remaining prescale phase.
- load with load_val=9, limit=6 -> count=6. load and clr in the same cycle -> count=0, ovf=0. load coincident with a wrap tick -> count=load value, tc=0.
- count=7, lower limit to 3: up tick -> count 0, tc=1. Down tick from 7 -> count 3, tc=0.
- limit=0, presc=0 -> count stays 0, tc high every enabled cycle. Assert rst asynchronously between edges -> count, tc, ovf read 0 before the next edge.

Source files
------------

// File: rtl/mod_updown_counter_if.sv
// Control and status bundle for mod_updown_counter.
// The controller (master) drives the control inputs and reads count/tc/ovf back.
interface mod_updown_counter_if #(
  parameter int WIDTH   = 8,
  parameter int PRESC_W = 4
);
  // No valid/ready pair: every control input is a level qualifier sampled on
  // each rising clk edge, and the outputs are registered copies of the state.
  logic               en;
  logic               up;
  logic               clr;
  logic               load;
  logic [WIDTH-1:0]   load_val;
  logic [WIDTH-1:0]   limit;
  logic [PRESC_W-1:0] presc;
  logic [WIDTH-1:0]   count;
  logic               tc;
  logic               ovf;

  modport master (
    output en, up, clr, load, load_val, limit, presc,
    input  count, tc, ovf
  );

  modport slave (
    input  en, up, clr, load, load_val, limit, presc,
    output count, tc, ovf
  );
endinterface

// File: rtl/mod_updown_counter.sv
// Programmable-modulus up/down counter with clock-enable prescaler,
// registered terminal-count pulse and sticky overflow flag.
module mod_updown_counter #(
  parameter int WIDTH   = 8,
  parameter int PRESC_W = 4
) (
  input logic                 i_clk,
  input logic                 i_rst_n,
  mod_updown_counter_if.slave if_bus
);

  logic [WIDTH-1:0]   r_count;
  logic [PRESC_W-1:0] r_presc_cnt;
  logic               r_tc;
  logic               r_ovf;

  logic [WIDTH-1:0]   w_count_nxt;
  logic [PRESC_W-1:0] w_presc_nxt;
  logic               w_tc_nxt;
  logic               w_ovf_nxt;
  logic               w_tick;
  logic               w_wrap;

  // A prescaler left above a lowered presc rolls over naturally at 2^PRESC_W.
  assign w_tick = if_bus.en && (r_presc_cnt == if_bus.presc);

  always_comb begin
    w_count_nxt = r_count;
    w_presc_nxt = r_presc_cnt;
    w_tc_nxt    = 1'b0;
    w_ovf_nxt   = r_ovf;
    w_wrap      = 1'b0;

    if (if_bus.clr) begin
      w_count_nxt = '0;
      w_presc_nxt = '0;
      w_ovf_nxt   = 1'b0;
    end else if (if_bus.load) begin
      w_count_nxt = (if_bus.load_val > if_bus.limit) ? if_bus.limit : if_bus.load_val;
      w_presc_nxt = '0;
    end else begin
      if (w_tick) begin
        w_presc_nxt = '0;
      end else if (if_bus.en) begin
        w_presc_nxt = r_presc_cnt + PRESC_W'(1);
      end

      if (w_tick) begin
        if (if_bus.up) begin
          if (r_count >= if_bus.limit) begin
            w_count_nxt = '0;
            w_wrap      = 1'b1;
          end else begin
            w_count_nxt = r_count + WIDTH'(1);
          end
        end else begin
          // A count stranded above a lowered limit snaps to limit without wrapping.
          if (r_count == '0) begin
            w_count_nxt = if_bus.limit;
            w_wrap      = 1'b1;
          end else if (r_count > if_bus.limit) begin
            w_count_nxt = if_bus.limit;
          end else begin
            w_count_nxt = r_count - WIDTH'(1);
          end
        end
      end

      if (w_wrap) begin
        w_tc_nxt  = 1'b1;
        w_ovf_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count     <= '0;
      r_presc_cnt <= '0;
      r_tc        <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      r_count     <= w_count_nxt;
      r_presc_cnt <= w_presc_nxt;
      r_tc        <= w_tc_nxt;
      r_ovf       <= w_ovf_nxt;
    end
  end

  assign if_bus.count = r_count;
  assign if_bus.tc    = r_tc;
  assign if_bus.ovf   = r_ovf;

endmodule

// File: tb/tb_mod_updown_counter.sv
// Self-checking bench for mod_updown_counter: directed scenarios followed by
// randomized traffic, all compared against an arithmetic reference model.
module tb_mod_updown_counter;

  localparam int WIDTH   = 8;
  localparam int PRESC_W = 4;
  localparam int MAXV    = (1 << WIDTH) - 1;
  localparam int PMOD    = 1 << PRESC_W;

  logic clk;
  logic rst_n;

  mod_updown_counter_if #(.WIDTH(WIDTH), .PRESC_W(PRESC_W)) bus ();

  mod_updown_counter #(.WIDTH(WIDTH), .PRESC_W(PRESC_W)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .if_bus  (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state
  int m_count;
  int m_pc;
  int m_tc;
  int m_ovf;

  int n_checks;
  int n_errors;
  logic [WIDTH-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic model_reset();
    m_count = 0;
    m_pc    = 0;
    m_tc    = 0;
    m_ovf   = 0;
  endtask

  // One rising edge of the specified behaviour, from the inputs being driven.
  task automatic model_edge();
    int lim;
    bit tick;
    lim = int'(bus.limit);
    if (bus.clr) begin
      model_reset();
    end else if (bus.load) begin
      m_count = (int'(bus.load_val) < lim) ? int'(bus.load_val) : lim;
      m_pc    = 0;
      m_tc    = 0;
    end else begin
      tick = bus.en && (m_pc == int'(bus.presc));
      m_tc = 0;
      if (tick) m_pc = 0;
      else if (bus.en) m_pc = (m_pc + 1) % PMOD;
      if (tick) begin
        if (bus.up) begin
          if (m_count >= lim) begin m_count = 0; m_tc = 1; end
          else m_count = m_count + 1;
        end else begin
          if (m_count == 0) begin m_count = lim; m_tc = 1; end
          else if (m_count > lim) m_count = lim;
          else m_count = m_count - 1;
        end
      end
      if (m_tc == 1) m_ovf = 1;
    end
  endtask

  // driver: one clock, then compare DUT outputs with the model
  task automatic step();
    logic [WIDTH-1:0] e;
    @(posedge clk);
    model_edge();
    exp_q.push_back(m_count[WIDTH-1:0]);
    #1;
    e = exp_q.pop_front();
    check("count", 32'(bus.count), 32'(e));
    check("tc", 32'(bus.tc), 32'(m_tc));
    check("ovf", 32'(bus.ovf), 32'(m_ovf));
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic set_ctl(input bit en_v, input bit up_v, input int lim_v, input int presc_v);
    bus.en    = en_v;
    bus.up    = up_v;
    bus.limit = WIDTH'(lim_v);
    bus.presc = PRESC_W'(presc_v);
  endtask

  task automatic pulse_clr();
    bus.clr = 1'b1;
    step();
    bus.clr = 1'b0;
  endtask

  task automatic do_load(input int v);
    bus.load     = 1'b1;
    bus.load_val = WIDTH'(v);
    step();
    bus.load     = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    model_reset();
    rst_n        = 1'b0;
    bus.clr      = 1'b0;
    bus.load     = 1'b0;
    bus.load_val = '0;
    set_ctl(1'b1, 1'b1, 5, 0);

    #2;
    check("rst_count", 32'(bus.count), 32'd0);
    check("rst_tc", 32'(bus.tc), 32'd0);
    check("rst_ovf", 32'(bus.ovf), 32'd0);
    #1 rst_n = 1'b1;

    // up count, limit 5
    steps(14);
    check("up14_count", 32'(bus.count), 32'd2);
    check("up14_ovf", 32'(bus.ovf), 32'd1);

    // down count from 0, limit 5
    pulse_clr();
    bus.up = 1'b0;
    step();
    check("down_wrap_count", 32'(bus.count), 32'd5);
    check("down_wrap_tc", 32'(bus.tc), 32'd1);
    steps(6);

    // prescaler with an enable gap mid-period
    pulse_clr();
    set_ctl(1'b1, 1'b1, 5, 3);
    steps(6);
    bus.en = 1'b0;
    steps(5);
    bus.en = 1'b1;
    steps(8);

    // load clamp, load+clr, load over a wrap tick
    set_ctl(1'b1, 1'b1, 6, 0);
    do_load(9);
    check("load_clamp", 32'(bus.count), 32'd6);
    bus.clr = 1'b1;
    do_load(3);
    bus.clr = 1'b0;
    check("clr_wins_count", 32'(bus.count), 32'd0);
    check("clr_wins_ovf", 32'(bus.ovf), 32'd0);
    do_load(6);
    do_load(2);
    check("load_over_wrap", 32'(bus.count), 32'd2);
    check("load_over_wrap_tc", 32'(bus.tc), 32'd0);

    // limit lowered below the current count
    set_ctl(1'b1, 1'b1, MAXV, 0);
    do_load(7);
    bus.limit = WIDTH'(3);
    step();
    check("lowered_up_count", 32'(bus.count), 32'd0);
    check("lowered_up_tc", 32'(bus.tc), 32'd1);
    bus.limit = WIDTH'(MAXV);
    do_load(7);
    bus.limit = WIDTH'(3);
    bus.up    = 1'b0;
    step();
    check("lowered_down_count", 32'(bus.count), 32'd3);
    check("lowered_down_tc", 32'(bus.tc), 32'd0);

    // full-range wrap
    set_ctl(1'b1, 1'b1, MAXV, 0);
    do_load(MAXV - 1);
    steps(3);

    // limit 0: every tick wraps
    set_ctl(1'b1, 1'b1, 0, 0);
    steps(5);

    // asynchronous reset between edges
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("async_count", 32'(bus.count), 32'd0);
    check("async_tc", 32'(bus.tc), 32'd0);
    check("async_ovf", 32'(bus.ovf), 32'd0);
    #1 rst_n = 1'b1;
    set_ctl(1'b1, 1'b1, 4, 1);
    steps(6);

    // randomized traffic, including presc changes that force rollover
    for (int i = 0; i < 800; i++) begin
      bus.clr      = ($urandom_range(0, 59) == 0);
      bus.load     = ($urandom_range(0, 24) == 0);
      bus.load_val = WIDTH'($urandom_range(0, MAXV));
      bus.en       = ($urandom_range(0, 9) != 0);
      bus.up       = $urandom_range(0, 1);
      if ($urandom_range(0, 29) == 0) begin
        case ($urandom_range(0, 3))
          0:       bus.limit = '0;
          1:       bus.limit = WIDTH'(MAXV);
          2:       bus.limit = WIDTH'($urandom_range(0, 15));
          default: bus.limit = WIDTH'($urandom_range(0, MAXV));
        endcase
      end
      if ($urandom_range(0, 39) == 0) begin
        bus.presc = ($urandom_range(0, 4) == 0) ? PRESC_W'(PMOD - 1)
                                                : PRESC_W'($urandom_range(0, 3));
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
